// File: rtl/decode_stage_if.sv
// Bundle between fetch/writeback and the decode stage, plus the ID/EX register
// fields handed on to execute.
interface decode_stage_if;
    logic [15:0] instruction_in;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        jump_taken;
    logic [15:0] jump_address;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic [3:0]  ex_rs1;
    logic [3:0]  ex_rs2;
    logic [15:0] ex_op_a;
    logic [15:0] ex_op_b;
    logic [15:0] ex_store_data;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    modport master (
        output instruction_in, wb_we, wb_addr, wb_data,
        input  stall, jump_taken, jump_address,
        input  ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2,
        input  ex_op_a, ex_op_b, ex_store_data,
        input  ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  instruction_in, wb_we, wb_addr, wb_data,
        output stall, jump_taken, jump_address,
        output ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2,
        output ex_op_a, ex_op_b, ex_store_data,
        output ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, 16x16 register file with write-through,
// load-use stall detection, JMP resolution and the ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int REG_AW     = 4
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'hA;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            opcode;
        logic [REG_AW-1:0]     rd;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic [DATA_WIDTH-1:0] op_a;
        logic [DATA_WIDTH-1:0] op_b;
        logic [DATA_WIDTH-1:0] store_data;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } idex_t;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    idex_t                 idex_r;
    idex_t                 idex_s;
    logic [3:0]            op_s;
    logic [REG_AW-1:0]     rd_s, rs1_s, rs2_s;
    logic [DATA_WIDTH-1:0] rd_val_s, rs1_val_s, rs2_val_s;
    logic                  use_rd_s, use_rs1_s, use_rs2_s;
    logic                  hazard_s, stall_s, jump_s;

    // Register read: R0 is hard zero, a same-cycle writeback is forwarded.
    function automatic logic [DATA_WIDTH-1:0] rf_read(
        input logic [REG_AW-1:0]     addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we,
        input logic [REG_AW-1:0]     waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        if (addr == {REG_AW{1'b0}}) begin
            return {DATA_WIDTH{1'b0}};
        end else if (we && (waddr == addr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    assign op_s  = bus.instruction_in[15:12];
    assign rd_s  = bus.instruction_in[11:8];
    assign rs1_s = bus.instruction_in[7:4];
    assign rs2_s = bus.instruction_in[3:0];

    assign rd_val_s  = rf_read(rd_s,  regs_r[rd_s],  bus.wb_we, bus.wb_addr, bus.wb_data);
    assign rs1_val_s = rf_read(rs1_s, regs_r[rs1_s], bus.wb_we, bus.wb_addr, bus.wb_data);
    assign rs2_val_s = rf_read(rs2_s, regs_r[rs2_s], bus.wb_we, bus.wb_addr, bus.wb_data);

    // Instruction decode into the next ID/EX contents and the set of used sources.
    always_comb begin
        idex_s    = '0;
        use_rd_s  = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                idex_s.valid     = 1'b1;
                idex_s.opcode    = op_s;
                idex_s.rd        = rd_s;
                idex_s.rs1       = rs1_s;
                idex_s.rs2       = rs2_s;
                idex_s.op_a      = rs1_val_s;
                idex_s.op_b      = rs2_val_s;
                idex_s.reg_write = (rd_s != {REG_AW{1'b0}});
                use_rs1_s        = 1'b1;
                use_rs2_s        = 1'b1;
            end
            OP_ADDI: begin
                idex_s.valid     = 1'b1;
                idex_s.opcode    = op_s;
                idex_s.rd        = rd_s;
                idex_s.rs1       = rs1_s;
                idex_s.op_a      = rs1_val_s;
                idex_s.op_b      = {{(DATA_WIDTH-4){bus.instruction_in[3]}}, bus.instruction_in[3:0]};
                idex_s.reg_write = (rd_s != {REG_AW{1'b0}});
                use_rs1_s        = 1'b1;
            end
            OP_LDI: begin
                idex_s.valid     = 1'b1;
                idex_s.opcode    = op_s;
                idex_s.rd        = rd_s;
                idex_s.op_b      = {{(DATA_WIDTH-8){1'b0}}, bus.instruction_in[7:0]};
                idex_s.reg_write = (rd_s != {REG_AW{1'b0}});
            end
            OP_LD: begin
                idex_s.valid     = 1'b1;
                idex_s.opcode    = op_s;
                idex_s.rd        = rd_s;
                idex_s.rs1       = rs1_s;
                idex_s.op_a      = rs1_val_s;
                idex_s.reg_write = (rd_s != {REG_AW{1'b0}});
                idex_s.mem_read  = 1'b1;
                use_rs1_s        = 1'b1;
            end
            OP_ST: begin
                // rd names the data register, so it is exported as rs2 for forwarding
                idex_s.valid      = 1'b1;
                idex_s.opcode     = op_s;
                idex_s.rd         = rd_s;
                idex_s.rs1        = rs1_s;
                idex_s.rs2        = rd_s;
                idex_s.op_a       = rs1_val_s;
                idex_s.store_data = rd_val_s;
                idex_s.mem_write  = 1'b1;
                use_rs1_s         = 1'b1;
                use_rd_s          = 1'b1;
            end
            OP_JMP: begin
                idex_s.valid  = 1'b1;
                idex_s.opcode = op_s;
            end
            default: begin
                idex_s = '0;
            end
        endcase
    end

    // Load-use hazard and jump resolution, both suppressed during reset.
    always_comb begin
        hazard_s = idex_r.valid && idex_r.mem_read && (idex_r.rd != {REG_AW{1'b0}}) &&
                   ((use_rs1_s && (rs1_s == idex_r.rd)) ||
                    (use_rs2_s && (rs2_s == idex_r.rd)) ||
                    (use_rd_s  && (rd_s  == idex_r.rd)));
        if (reset) begin
            stall_s = 1'b0;
            jump_s  = 1'b0;
        end else begin
            stall_s = hazard_s;
            jump_s  = (op_s == OP_JMP);
        end
    end

    // Register file storage; R0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (bus.wb_we && (bus.wb_addr != {REG_AW{1'b0}})) begin
            regs_r[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ID/EX pipeline register; a stall inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_r <= '0;
        end else if (stall_s) begin
            idex_r <= '0;
        end else begin
            idex_r <= idex_s;
        end
    end

    assign bus.stall         = stall_s;
    assign bus.jump_taken    = jump_s;
    assign bus.jump_address  = {{(DATA_WIDTH-12){1'b0}}, bus.instruction_in[11:0]};
    assign bus.ex_valid      = idex_r.valid;
    assign bus.ex_opcode     = idex_r.opcode;
    assign bus.ex_rd         = idex_r.rd;
    assign bus.ex_rs1        = idex_r.rs1;
    assign bus.ex_rs2        = idex_r.rs2;
    assign bus.ex_op_a       = idex_r.op_a;
    assign bus.ex_op_b       = idex_r.op_b;
    assign bus.ex_store_data = idex_r.store_data;
    assign bus.ex_reg_write  = idex_r.reg_write;
    assign bus.ex_mem_read   = idex_r.mem_read;
    assign bus.ex_mem_write  = idex_r.mem_write;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode operands, regfile bypass, load-use
// stall, JMP resolution and reset behaviour.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    decode_stage_if dif();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic we,
                         input logic [3:0] waddr, input logic [15:0] wdata);
        dif.instruction_in = instr;
        dif.wb_we          = we;
        dif.wb_addr        = waddr;
        dif.wb_data        = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset with a JMP in decode and a writeback that must be discarded
        drive(16'hAABC, 1'b1, 4'd7, 16'h5555);
        tick;
        tick;
        chk("rst_stall",     16'(dif.stall),        16'h0000);
        chk("rst_jump",      16'(dif.jump_taken),   16'h0000);
        chk("rst_valid",     16'(dif.ex_valid),     16'h0000);
        chk("rst_opcode",    16'(dif.ex_opcode),    16'h0000);
        chk("rst_op_a",      dif.ex_op_a,           16'h0000);
        chk("rst_op_b",      dif.ex_op_b,           16'h0000);
        chk("rst_regwr",     16'(dif.ex_reg_write), 16'h0000);
        reset = 1'b0;

        drive(16'h1172, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("add_valid",     16'(dif.ex_valid),     16'h0001);
        chk("r7_discarded",  dif.ex_op_a,           16'h0000);
        chk("add_rs1",       16'(dif.ex_rs1),       16'h0007);
        chk("add_rs2",       16'(dif.ex_rs2),       16'h0002);

        drive(16'h1130, 1'b1, 4'd3, 16'h1234);
        tick;
        chk("bypass_op_a",   dif.ex_op_a,           16'h1234);
        chk("bypass_op_b",   dif.ex_op_b,           16'h0000);
        chk("add_regwr",     16'(dif.ex_reg_write), 16'h0001);
        chk("add_rd",        16'(dif.ex_rd),        16'h0001);

        drive(16'h62FF, 1'b1, 4'd1, 16'h0010);
        tick;
        chk("ldi_op_a",      dif.ex_op_a,           16'h0000);
        chk("ldi_op_b",      dif.ex_op_b,           16'h00FF);
        chk("ldi_rd",        16'(dif.ex_rd),        16'h0002);
        chk("ldi_rs1",       16'(dif.ex_rs1),       16'h0000);

        drive(16'h541F, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("addi_op_a",     dif.ex_op_a,           16'h0010);
        chk("addi_op_b",     dif.ex_op_b,           16'hFFFF);
        chk("addi_rs2",      16'(dif.ex_rs2),       16'h0000);

        drive(16'h7510, 1'b0, 4'd0, 16'h0000);
        #1 chk("ld_no_stall", 16'(dif.stall),       16'h0000);
        tick;
        chk("ld_memrd",      16'(dif.ex_mem_read),  16'h0001);
        chk("ld_op_a",       dif.ex_op_a,           16'h0010);
        chk("ld_rd",         16'(dif.ex_rd),        16'h0005);

        // dependent ADD: one stall cycle, then re-decode with r5 forwarded
        drive(16'h1652, 1'b1, 4'd2, 16'h00FF);
        #1 chk("lu_stall",    16'(dif.stall),       16'h0001);
        tick;
        chk("bubble_valid",  16'(dif.ex_valid),     16'h0000);
        chk("bubble_opcode", 16'(dif.ex_opcode),    16'h0000);
        chk("bubble_regwr",  16'(dif.ex_reg_write), 16'h0000);
        drive(16'h1652, 1'b1, 4'd5, 16'h0777);
        #1 chk("stall_1cyc",  16'(dif.stall),       16'h0000);
        tick;
        chk("reissue_valid", 16'(dif.ex_valid),     16'h0001);
        chk("reissue_rd",    16'(dif.ex_rd),        16'h0006);
        chk("reissue_op_a",  dif.ex_op_a,           16'h0777);
        chk("reissue_op_b",  dif.ex_op_b,           16'h00FF);

        drive(16'h7510, 1'b0, 4'd0, 16'h0000);
        tick;
        drive(16'h1622, 1'b0, 4'd0, 16'h0000);
        #1 chk("indep_stall", 16'(dif.stall),       16'h0000);
        tick;
        chk("indep_valid",   16'(dif.ex_valid),     16'h0001);
        chk("indep_op_a",    dif.ex_op_a,           16'h00FF);

        drive(16'h7010, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("ld_r0_regwr",   16'(dif.ex_reg_write), 16'h0000);
        drive(16'h1600, 1'b0, 4'd0, 16'h0000);
        #1 chk("ld_r0_stall", 16'(dif.stall),       16'h0000);
        tick;
        chk("after_r0_valid", 16'(dif.ex_valid),    16'h0001);

        drive(16'h8310, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("st_data",       dif.ex_store_data,     16'h1234);
        chk("st_rs2",        16'(dif.ex_rs2),       16'h0003);
        chk("st_memwr",      16'(dif.ex_mem_write), 16'h0001);
        chk("st_regwr",      16'(dif.ex_reg_write), 16'h0000);
        chk("st_op_a",       dif.ex_op_a,           16'h0010);

        drive(16'hAABC, 1'b0, 4'd0, 16'h0000);
        #1;
        chk("jmp_taken",     16'(dif.jump_taken),   16'h0001);
        chk("jmp_addr",      dif.jump_address,      16'h0ABC);
        chk("jmp_stall",     16'(dif.stall),        16'h0000);
        tick;
        chk("jmp_valid",     16'(dif.ex_valid),     16'h0001);
        chk("jmp_opcode",    16'(dif.ex_opcode),    16'h000A);
        chk("jmp_regwr",     16'(dif.ex_reg_write), 16'h0000);
        chk("jmp_memrd",     16'(dif.ex_mem_read),  16'h0000);
        chk("jmp_memwr",     16'(dif.ex_mem_write), 16'h0000);

        drive(16'h1100, 1'b1, 4'd0, 16'hFFFF);
        #1 chk("nojmp_taken", 16'(dif.jump_taken),  16'h0000);
        tick;
        chk("r0_bypass",     dif.ex_op_a,           16'h0000);
        drive(16'h1100, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("r0_stored",     dif.ex_op_a,           16'h0000);

        drive(16'h9123, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("op9_valid",     16'(dif.ex_valid),     16'h0000);
        chk("op9_opcode",    16'(dif.ex_opcode),    16'h0000);

        // reset asserted in a stall cycle
        drive(16'h7510, 1'b0, 4'd0, 16'h0000);
        tick;
        drive(16'h1652, 1'b0, 4'd0, 16'h0000);
        #1 chk("pre_rst_stall", 16'(dif.stall),     16'h0001);
        reset = 1'b1;
        #1 chk("rst_gates_stall", 16'(dif.stall),   16'h0000);
        tick;
        chk("rst_stall_valid", 16'(dif.ex_valid),   16'h0000);
        chk("rst_stall_op_a",  dif.ex_op_a,         16'h0000);
        chk("rst_stall_memrd", 16'(dif.ex_mem_read), 16'h0000);
        chk("rst_stall_out",   16'(dif.stall),      16'h0000);
        reset = 1'b0;
        drive(16'h1130, 1'b0, 4'd0, 16'h0000);
        tick;
        chk("r3_cleared",    dif.ex_op_a,           16'h0000);
        chk("post_rst_valid", 16'(dif.ex_valid),    16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
